pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer: next generation of the single-step PC register.
//  Adds configurable width/step/reset vector, stall, absolute load, and call/return via a
//  circular return-address stack (RAS). Sits between control unit and bus (pc_out -> BusMuxIn_PC).
// PARAMETERS
//  WIDTH     32  PC / data width in bits
//  INC       1   increment step added per advance (unsigned, < 2**WIDTH)
//  RESET_PC  0   value loaded into pc_out on clr
//  RAS_DEPTH 4   RAS entries (power of 2, >= 2)
// PORTS
//  clk           in   1      single clock; all state updates on rising edge
//  clr           in   1      synchronous, active-high reset
//  stall         in   1      freeze PC and RAS for this cycle
//  pc_increment  in   1      advance: pc_out <= pc_out + INC
//  enable        in   1      absolute load: pc_out <= pc_in
//  call          in   1      push pc_next onto RAS, then load pc_in
//  ret           in   1      pop RAS top into pc_out
//  pc_in         in   WIDTH  load/call target (BusMuxOut)
//  pc_out        out  WIDTH  current PC (registered)
//  pc_next       out  WIDTH  combinational pc_out + INC, modulo 2**WIDTH
//  ras_top       out  WIDTH  current top-of-stack (0 when empty)
//  ras_empty     out  1      stack holds 0 entries
//  ras_full      out  1      stack holds RAS_DEPTH entries
//  ras_err       out  1      sticky: overflow or underflow since last clr
// BEHAVIOUR
//  - Reset: clr at posedge -> pc_out=RESET_PC, RAS count=0, ptr=0, ras_err=0; pc_next=RESET_PC+INC,
//    ras_top=0, ras_empty=1, ras_full=0 from that edge. clr overrides every other input.
//  - Priority per cycle (highest first): clr > stall > ret > call > enable > pc_increment > hold.
//  - stall: pc_out, RAS contents/pointer/count and ras_err unchanged.
//  - pc_increment: pc_out <= pc_out+INC; wraps at 2**WIDTH silently (no error).
//  - enable: pc_out <= pc_in. Latency 1 cycle for all ops; pc_out is the only PC state.
//  - call (not ret): RAS push pc_next; pc_out <= pc_in. When full: overwrite oldest entry
//    (circular), count stays RAS_DEPTH, ras_err <= 1.
//  - ret (not call): pc_out <= ras_top; pop, count-1. When empty: pc_out <= pc_next (falls
//    through as increment), count stays 0, ras_err <= 1.
//  - call & ret same cycle: pc_out <= pc_in; top entry replaced by pc_next (count unchanged);
//    if empty, acts as plain call push (count 0->1), no error.
//  - enable/pc_increment asserted together with call/ret are ignored that cycle.
//  - ras_err only cleared by clr. Reset mid-call/ret: clr wins, no push/pop performed.
// CONFIGURATION
//  PC_SEQ_RAS_EN defined: RAS present as above.
//  PC_SEQ_RAS_EN undefined: no RAS storage; call behaves exactly as enable; ret ignored
//   (next-lower priority input applies); ras_top=0, ras_empty=1, ras_full=0, ras_err=0 constant.
// STRUCTURE
//  - pc_seq_pkg: localparam op encodings (OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET, OP_SWAP),
//    priority-decode function returning op, clog2 helper for RAS pointer width.
//  - Sub-module ras_stack (WIDTH, RAS_DEPTH): circular array, ptr, count, push/pop/swap,
//    top/empty/full/err outputs; instantiated only under PC_SEQ_RAS_EN.
//  - Top: op decode, PC register, pc_next adder.
// TESTING
//  1. clr with RESET_PC=0x100, INC=4 -> pc_out=0x100, pc_next=0x104, ras_empty=1, ras_err=0.
//  2. pc_increment x3 from 0x100 -> 0x104,0x108,0x10C; pc_out=0xFFFFFFFC + inc -> 0x0, no err.
//  3. pc_out=0x10, call pc_in=0x80 -> pc_out=0x80, ras_top=0x14; ret -> pc_out=0x14, ras_empty=1.
//  4. RAS_DEPTH=4: 5 calls -> ras_full=1, ras_err=1, 4 rets return last 4 pushes in LIFO order;
//     5th ret on empty -> pc_out=pc_next, ras_err stays 1.
//  5. stall=1 with ret, enable, pc_increment all high -> pc_out and RAS unchanged; clr+stall -> reset.
//  6. call&ret together (top=0x20, pc_out=0x40, pc_in=0x90, INC=4) -> pc_out=0x90, ras_top=0x44,
//     count unchanged; rebuild without PC_SEQ_RAS_EN -> call loads 0x90, ret ignored, flags const.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
//   Shared definitions for the program-counter sequencer:
//   - op_t / OP_* : one operation per cycle, chosen by decode_op()
//   - clog2()     : pointer width helper for the return-address stack
//   - decode_op() : fixed priority stall > ret > call > enable > pc_increment
// ---------------------------------------------------------------------------
package pc_seq_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_HOLD = 3'd0;
  localparam op_t OP_INC  = 3'd1;
  localparam op_t OP_LOAD = 3'd2;
  localparam op_t OP_CALL = 3'd3;
  localparam op_t OP_RET  = 3'd4;
  localparam op_t OP_SWAP = 3'd5;  // call and ret together: replace top entry

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // Without a stack, call degrades to a plain load and ret is invisible,
  // so the next-lower input in the priority chain takes effect.
  function automatic op_t decode_op(input logic ras_en, input logic stall,
                                    input logic ret, input logic call,
                                    input logic enable, input logic inc);
    op_t op;
    op = OP_HOLD;
    if (stall)                      op = OP_HOLD;
    else if (ras_en && ret && call) op = OP_SWAP;
    else if (ras_en && ret)         op = OP_RET;
    else if (call)                  op = ras_en ? OP_CALL : OP_LOAD;
    else if (enable)                op = OP_LOAD;
    else if (inc)                   op = OP_INC;
    return op;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//   Control/bus side of the PC sequencer.
//   master (control unit): drives stall, pc_increment, enable, call, ret,
//                          pc_in; observes pc_out, pc_next and RAS flags.
//   slave  (sequencer)   : the reverse.
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(parameter int WIDTH = 32);

  logic             stall;
  logic             pc_increment;
  logic             enable;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;

  modport master (
    output stall, pc_increment, enable, call, ret, pc_in,
    input  pc_out, pc_next, ras_top, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, pc_increment, enable, call, ret, pc_in,
    output pc_out, pc_next, ras_top, ras_empty, ras_full, ras_err
  );

endinterface

// File: rtl/ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack
//   Circular return-address stack.
//   Ports: clk, clr (sync active-high), push, pop, swap, din (WIDTH),
//          top (0 when empty), empty, full, err (sticky over/underflow).
//   ptr addresses the next free slot; once full, that slot is the oldest
//   entry, so a push on a full stack overwrites it with no extra logic.
//   push/pop/swap are expected to be mutually exclusive (one op per cycle).
// ---------------------------------------------------------------------------
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic             swap,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             err
);

  localparam int PTR_W = clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             err_reg;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_addr;
  logic             wr_en;

  assign top_idx = ptr_reg - PTR_W'(1);
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(RAS_DEPTH));
  assign err     = err_reg;
  assign top     = empty ? '0 : mem[top_idx];

  // A swap on an empty stack degenerates into a push at ptr.
  assign wr_en   = !clr && (push || swap);
  assign wr_addr = (swap && !empty) ? top_idx : ptr_reg;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_reg   <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else if (push) begin
      ptr_reg <= ptr_reg + PTR_W'(1);
      if (full) err_reg   <= 1'b1;
      else      count_reg <= count_reg + CNT_W'(1);
    end else if (pop) begin
      if (empty) begin
        err_reg <= 1'b1;
      end else begin
        ptr_reg   <= top_idx;
        count_reg <= count_reg - CNT_W'(1);
      end
    end else if (swap && empty) begin
      ptr_reg   <= ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter register with increment, absolute load, stall and
//   (optionally) call/return through a circular return-address stack.
//   Ports: clk, clr (sync active-high reset),
//          bus (pc_sequencer_if.slave): controls in, pc_out/pc_next/RAS out.
//   Build option: define PC_SEQ_RAS_EN to include the return-address stack.
//   Without it call acts as a load, ret is ignored and the RAS flags are
//   tied to their empty/no-error values.
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] INC       = 1,
  parameter logic [WIDTH-1:0] RESET_PC  = 0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic           clk,
  input  logic           clr,
  pc_sequencer_if.slave  bus
);

`ifdef PC_SEQ_RAS_EN
  localparam logic RAS_EN = 1'b1;
`else
  localparam logic RAS_EN = 1'b0;
`endif

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;
  op_t              op;

  assign pc_next = pc_reg + INC;
  assign op      = decode_op(RAS_EN, bus.stall, bus.ret, bus.call,
                             bus.enable, bus.pc_increment);

  always_ff @(posedge clk) begin
    if (clr) begin
      pc_reg <= RESET_PC;
    end else begin
      case (op)
        OP_INC:                    pc_reg <= pc_next;
        OP_LOAD, OP_CALL, OP_SWAP: pc_reg <= bus.pc_in;
        // Underflowing ret falls through as an increment.
        OP_RET:                    pc_reg <= ras_empty ? pc_next : ras_top;
        default:                   pc_reg <= pc_reg;
      endcase
    end
  end

`ifdef PC_SEQ_RAS_EN
  // The return address pushed on call (or swapped in) is always pc_next.
  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .clr   (clr),
    .push  (op == OP_CALL),
    .pop   (op == OP_RET),
    .swap  (op == OP_SWAP),
    .din   (pc_next),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .err   (ras_err)
  );
`else
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;
`endif

  assign bus.pc_out    = pc_reg;
  assign bus.pc_next   = pc_next;
  assign bus.ras_top   = ras_top;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_err   = ras_err;

endmodule
